// File: rtl/pe_mac_ctrl_pkg.sv
// pe_pkg: shared definitions for the pe_mac_ctrl dot-product controller.
//   - FP16 field widths and the FP16 zero encoding
//   - FSM state enum
//   - helper to detect an all-ones (Inf/NaN) FP16 exponent
package pe_pkg;

    localparam int unsigned EXPONENT = 5;
    localparam int unsigned MANTISSA = 10;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } pe_state_e;

    // True for Inf and NaN encodings.
    function automatic logic fp16_is_exp_max(input logic [15:0] v);
        return &v[MANTISSA +: EXPONENT];
    endfunction

endpackage

// File: rtl/pe_mac_ctrl.sv
// pe_mac_ctrl: control and pipeline for one FP16 dot product using an external
// combinational multiplier and adder.
//
// Operation: start (in IDLE) latches k_len and clears the accumulator. In RUN,
// up to k_len operand pairs are accepted (one per cycle). Stage 1 registers the
// product, stage 2 folds it into the accumulator, so a pair reaches acc two
// cycles after acceptance. DONE presents the result until out_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, k_len             begin a dot product of k_len pairs
//   in_valid/in_ready        operand-pair handshake, operands on a_in/b_in
//   mul_a, mul_b, mul_prod   external multiplier interface
//   add_par_sum, add_mult_prod, add_sum   external adder interface
//   out_valid/out_ready      result handshake, value on result
//   busy                     high whenever the FSM is not in IDLE
//   exc_flag                 (only with PE_MAC_EXC_FLAG_EN) sticky flag set when
//                            an accepted operand has an all-ones exponent
//
// Build option: define PE_MAC_EXC_FLAG_EN to add the exc_flag port and logic.
module pe_mac_ctrl
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic [DATA_WIDTH-1:0] mul_prod,
    output logic [DATA_WIDTH-1:0] add_par_sum,
    output logic [DATA_WIDTH-1:0] add_mult_prod,
    input  logic [DATA_WIDTH-1:0] add_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
`ifdef PE_MAC_EXC_FLAG_EN
    ,
    output logic                  exc_flag
`endif
);

    pe_state_e r_state;
    pe_state_e w_state_next;

    logic [CNT_WIDTH-1:0]  r_k_len;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_p_reg;
    logic                  r_p_vld;

    logic w_start_acc;
    logic w_accept;
    logic w_cnt_below;

    // Count stops advancing once it equals k_len (in_ready drops), so the
    // increment can never wrap, even for an all-ones k_len.
    assign w_cnt_inc   = r_cnt + CNT_WIDTH'(1);
    assign w_cnt_below = (r_cnt < r_k_len);

    // Multiplier and adder are external and combinational.
    assign mul_a         = a_in;
    assign mul_b         = b_in;
    assign add_par_sum   = r_acc;
    assign add_mult_prod = r_p_reg;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        result       = '0;
        busy         = 1'b1;

        case (r_state)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = (k_len == '0) ? StDone : StRun;
                end
            end

            StRun: begin
                in_ready = w_cnt_below;
                w_accept = in_valid && w_cnt_below;
                if (w_accept && (w_cnt_inc == r_k_len)) begin
                    w_state_next = StDrain;
                end
            end

            // Entered right after the last accept: p_vld holds the final
            // product and it lands in acc on this same edge, so DONE sees
            // the complete sum.
            StDrain: begin
                w_state_next = StDone;
            end

            StDone: begin
                out_valid = 1'b1;
                result    = r_acc;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Length/count registers and the two-stage product/accumulate pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_len <= '0;
            r_cnt   <= '0;
            r_p_reg <= '0;
            r_p_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            if (w_start_acc) begin
                r_k_len <= k_len;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_inc;
            end

            // Stage 1: register the product of the accepted pair.
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_p_reg <= mul_prod;
            end

            // Stage 2: fold the registered product into the accumulator.
            // start (IDLE only) and p_vld (RUN/DRAIN only) never coincide.
            if (w_start_acc) begin
                r_acc <= DATA_WIDTH'(FP16_ZERO);
            end else if (r_p_vld) begin
                r_acc <= add_sum;
            end
        end
    end

`ifdef PE_MAC_EXC_FLAG_EN
    logic r_exc;
    logic w_exc_hit;

    assign w_exc_hit = fp16_is_exp_max(16'(a_in)) || fp16_is_exp_max(16'(b_in));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc <= 1'b0;
        end else if (w_start_acc) begin
            r_exc <= 1'b0;
        end else if (w_accept && w_exc_hit) begin
            r_exc <= 1'b1;
        end
    end

    assign exc_flag = r_exc;
`endif

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Self-checking bench for pe_mac_ctrl. A small FP16 multiplier/adder table
// model stands in for the external arithmetic; expected results are queued
// when each dot product is issued and a monitor pops and compares them on
// every out_valid&out_ready cycle.
module tb_pe_mac_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] mul_prod;
    logic [DW-1:0] add_par_sum;
    logic [DW-1:0] add_mult_prod;
    logic [DW-1:0] add_sum;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          busy;
`ifdef PE_MAC_EXC_FLAG_EN
    logic          exc_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];

    pe_mac_ctrl #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_prod     (mul_prod),
        .add_par_sum  (add_par_sum),
        .add_mult_prod(add_mult_prod),
        .add_sum      (add_sum),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .busy         (busy)
`ifdef PE_MAC_EXC_FLAG_EN
        ,
        .exc_flag     (exc_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table-driven FP16 arithmetic for the operand values used here.
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        if ((&a[14:10]) || (&b[14:10])) return 16'h7C00;
        case ({a, b})
            {16'h3C00, 16'h3C00}: return 16'h3C00;
            {16'h3C00, 16'h4000}: return 16'h4000;
            {16'h4000, 16'h3C00}: return 16'h4000;
            {16'h4000, 16'h4000}: return 16'h4400;
            default:              return 16'hDEAD;
        endcase
    endfunction

    // Inf/NaN operands flush to zero in this adder model.
    function automatic logic [15:0] fadd(input logic [15:0] p, input logic [15:0] q);
        if ((&p[14:10]) || (&q[14:10])) return 16'h0000;
        if (p == 16'h0000) return q;
        if (q == 16'h0000) return p;
        case ({p, q})
            {16'h4000, 16'h4400}: return 16'h4600;
            {16'h4400, 16'h4000}: return 16'h4600;
            {16'h3C00, 16'h3C00}: return 16'h4000;
            {16'h4000, 16'h3C00}: return 16'h4200;
            {16'h3C00, 16'h4000}: return 16'h4200;
            default:              return 16'hBEEF;
        endcase
    endfunction

    always_comb mul_prod = fmul(mul_a, mul_b);
    always_comb add_sum  = fadd(add_par_sum, add_mult_prod);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i = 0;
        while (!out_valid && i < budget) begin
            tick();
            i++;
        end
        if (!out_valid) check(name, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;

        // Monitor: compare every presented result against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %0h, required no result", result);
                    end else begin
                        check("result", {16'd0, result}, {16'd0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset state.
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // k_len=2, back-to-back pairs: 1*2 + 2*2 = 6.0, valid 3 cycles after first accept.
        start = 1'b1;
        k_len = 8'd2;
        tick();
        start = 1'b0;
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a_in     = 16'h3C00;
        b_in     = 16'h4000;
        check("t2_mul_b", {16'd0, mul_b}, 32'h4000);
        exp_q.push_back(16'h4600);
        tick();
        a_in = 16'h4000;
        b_in = 16'h4000;
        check("t2_in_ready_2nd", {31'd0, in_ready}, 32'd1);
        check("t2_out_valid_early", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("t2_in_ready_drain", {31'd0, in_ready}, 32'd0);
        check("t2_out_valid_c2", {31'd0, out_valid}, 32'd0);
        tick();
        check("t2_out_valid_c3", {31'd0, out_valid}, 32'd1);
        tick();
        check("t2_idle_busy", {31'd0, busy}, 32'd0);

        // k_len=0: straight to DONE with zero, in_ready never high.
        start = 1'b1;
        k_len = 8'd0;
        exp_q.push_back(16'h0000);
        tick();
        start = 1'b0;
        check("t0_out_valid", {31'd0, out_valid}, 32'd1);
        check("t0_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("t0_idle_busy", {31'd0, busy}, 32'd0);
        check("t0_in_ready_idle", {31'd0, in_ready}, 32'd0);

        // k_len=3 with 2-cycle gaps, 1.0*1.0 each -> 3.0.
        start = 1'b1;
        k_len = 8'd3;
        tick();
        start = 1'b0;
        exp_q.push_back(16'h4200);
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1;
            a_in     = 16'h3C00;
            b_in     = 16'h3C00;
            tick();
            in_valid = 1'b0;
            if (p < 2) begin
                check("t3_in_ready_gap", {31'd0, in_ready}, 32'd1);
                repeat (2) tick();
            end else begin
                check("t3_in_ready_after_last", {31'd0, in_ready}, 32'd0);
            end
        end
        wait_valid("t3_wait_valid", 10);
        tick();

        // Backpressure: out_ready low 5 cycles, result held, start ignored.
        out_ready = 1'b0;
        start     = 1'b1;
        k_len     = 8'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'h3C00;
        b_in     = 16'h4000;
        exp_q.push_back(16'h4000);
        tick();
        in_valid = 1'b0;
        wait_valid("bp_wait_valid", 10);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_result_hold", {16'd0, result}, 32'h4000);
            start = 1'b1;
            k_len = 8'd5;
            tick();
        end
        start = 1'b0;
        check("bp_out_valid_end", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-RUN after 1 of 4 pairs, then a clean k_len=1 run.
        start = 1'b1;
        k_len = 8'd4;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'h3C00;
        b_in     = 16'h3C00;
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mr_in_ready", {31'd0, in_ready}, 32'd0);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();
        check("mr_no_partial", {31'd0, out_valid}, 32'd0);
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'h3C00;
        b_in     = 16'h3C00;
        exp_q.push_back(16'h3C00);
        tick();
        in_valid = 1'b0;
        wait_valid("mr_wait_valid", 10);
        tick();

`ifdef PE_MAC_EXC_FLAG_EN
        // Inf operand: sticky flag until the next start, sum flushes to zero.
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        check("exc_clear_initial", {31'd0, exc_flag}, 32'd0);
        in_valid = 1'b1;
        a_in     = 16'h7C00;
        b_in     = 16'h3C00;
        exp_q.push_back(16'h0000);
        tick();
        in_valid = 1'b0;
        check("exc_set", {31'd0, exc_flag}, 32'd1);
        wait_valid("exc_wait_valid", 10);
        tick();
        check("exc_held_idle", {31'd0, exc_flag}, 32'd1);
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        check("exc_cleared_by_start", {31'd0, exc_flag}, 32'd0);
        in_valid = 1'b1;
        a_in     = 16'h3C00;
        b_in     = 16'h3C00;
        exp_q.push_back(16'h3C00);
        tick();
        in_valid = 1'b0;
        wait_valid("exc_wait_valid2", 10);
        tick();
`endif

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mac_ctrl.md
PE_MAC_CTRL -- requirements
Module: pe_mac_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FP16 operand/result width.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the dot-product length field.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a new dot product (sampled in IDLE only).
REQ-006 SHALL have port k_len  input  CNT_WIDTH  number of element pairs; latched on accepted start.
REQ-007 SHALL have ports in_valid input 1 / in_ready output 1  operand-pair handshake.
REQ-008 SHALL have ports a_in, b_in  input  DATA_WIDTH  FP16 operand pair.
REQ-009 SHALL have ports mul_a, mul_b  output  DATA_WIDTH  to the combinational FP16 multiplier, equal to a_in and b_in respectively.
REQ-010 SHALL have port mul_prod  input  DATA_WIDTH  multiplier result.
REQ-011 SHALL have ports add_par_sum, add_mult_prod  output  DATA_WIDTH  to the combinational FP16 adder, driven from the accumulator and the product register respectively.
REQ-012 SHALL have port add_sum  input  DATA_WIDTH  adder result.
REQ-013 SHALL have ports out_valid output 1 / out_ready input 1 / result output DATA_WIDTH  result handshake.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: start=1 SHALL latch k_len, clear the accumulator to 0x0000, clear the accepted-count, and move to RUN, or to DONE when k_len=0.
REQ-017 RUN: in_ready SHALL be 1 while accepted-count < latched k_len and 0 otherwise; a pair is accepted only when in_valid&in_ready.
REQ-018 Stage 1: on accept, p_reg SHALL capture mul_prod and p_vld SHALL be set for one cycle; otherwise p_vld SHALL clear.
REQ-019 Stage 2: when p_vld=1, acc SHALL capture add_sum; add_par_sum=acc and add_mult_prod=p_reg at all times.
REQ-020 Throughput SHALL be one pair per cycle; latency from acceptance of a pair to its inclusion in acc SHALL be 2 cycles.
REQ-021 The accept of the last pair (count reaches k_len) SHALL move RUN to DRAIN; DRAIN SHALL move to DONE once p_vld=0 and the final accumulate has been written.
REQ-022 DONE: out_valid SHALL be 1 and result SHALL equal acc, both held stable until out_ready=1; the cycle with out_valid&out_ready SHALL return the FSM to IDLE.
REQ-023 start outside IDLE SHALL be ignored; in_valid outside RUN SHALL be ignored, with in_ready=0.
REQ-024 The count SHALL saturate at k_len and never wrap; k_len of all-ones SHALL be supported.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, acc=0, p_reg=0, p_vld=0, count=0, in_ready=0, out_valid=0, result=0, busy=0, including in the middle of an operation; no partial result SHALL be emitted afterwards.

Configuration
REQ-026 With PE_MAC_EXC_FLAG_EN defined, a port exc_flag (output, 1) SHALL be added and set sticky when any accepted a_in or b_in has exponent 5'b11111. It SHALL clear on an accepted start or on rst.
REQ-027 Without PE_MAC_EXC_FLAG_EN, the port and its logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 A shared package pe_pkg SHALL hold the FSM state enum typedef, the FP16 field widths (EXPONENT=5, MANTISSA=10) and FP16_ZERO=16'h0000.
REQ-029 The multiplier and adder SHALL stay outside this block. No sub-module is required; the two-stage product/accumulate pipeline SHALL remain inline.

Verification
REQ-030 k_len=2, pairs (0x3C00,0x4000),(0x4000,0x4000) back-to-back -> result=0x4600 (6.0), out_valid 3 cycles after the first accept.
REQ-031 k_len=0, start -> DONE the next cycle, result=0x0000, in_ready never asserted.
REQ-032 k_len=3 with in_valid gaps of 2 cycles, pairs of 1.0*1.0 -> result=0x4200 (3.0); in_ready drops after the third accept.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid and result stable; start pulses during that time are ignored.
REQ-034 rst asserted mid-RUN after 1 of 4 pairs -> all outputs 0 in the same cycle; a new start with k_len=1, (0x3C00,0x3C00) -> result=0x3C00.
REQ-035 With PE_MAC_EXC_FLAG_EN, a_in=0x7C00 accepted -> exc_flag=1 and held until the next start; result=0x0000 (adder flush).
